// File: rtl/reg_pipe.sv
// reg_pipe: elastic WIDTH-bit register pipeline with valid/ready on both
// sides, bubble collapsing, synchronous flush and an occupancy count.
module reg_pipe #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      STAGES  = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_flush,
    input  logic [WIDTH-1:0]              i_din,
    input  logic                          i_din_valid,
    output logic                          o_din_ready,
    output logic [WIDTH-1:0]              o_dout,
    output logic                          o_dout_valid,
    input  logic                          i_dout_ready,
    output logic [$clog2(STAGES+1)-1:0]   o_count
);

    localparam int unsigned CW = $clog2(STAGES + 1);

    logic [WIDTH-1:0]  r_data [STAGES];
    logic [STAGES-1:0] r_valid;
    logic [CW-1:0]     r_count;

    logic [STAGES-1:0] w_ready;
    logic              w_in;
    logic              w_out;

    // A stage can load when the consumer takes a word or any stage at or
    // downstream of it is empty; this is the unrolled ready chain.
    for (genvar g = 0; g < STAGES; g++) begin : g_rdy
        assign w_ready[g] = i_dout_ready | ~(&r_valid[STAGES-1:g]);
    end

    assign o_din_ready  = w_ready[0] & ~i_flush;
    assign w_in         = i_din_valid & o_din_ready;
    assign w_out        = r_valid[STAGES-1] & i_dout_ready;

    assign o_dout       = r_data[STAGES-1];
    assign o_dout_valid = r_valid[STAGES-1];
    assign o_count      = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= RST_VAL;
            end
        end else if (i_flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            if (w_ready[0]) begin
                r_data[0]  <= i_din;
                r_valid[0] <= i_din_valid;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_ready[i]) begin
                    r_data[i]  <= r_data[i-1];
                    r_valid[i] <= r_valid[i-1];
                end
            end
            r_count <= r_count + CW'(w_in) - CW'(w_out);
        end
    end

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed and random stimulus; a negedge monitor checks
// outputs against a scoreboard queue and an occupancy model.
module tb_reg_pipe;

    localparam int W  = 8;
    localparam int S  = 3;
    localparam int CW = $clog2(S + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [W-1:0]  din;
    logic          din_valid;
    logic          din_ready;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] sb_q [$];
    int           mdl_cnt = 0;
    logic         armed = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_dout = '0;

    reg_pipe #(.WIDTH(W), .STAGES(S), .RST_VAL('0)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_din        (din),
        .i_din_valid  (din_valid),
        .o_din_ready  (din_ready),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .i_dout_ready (dout_ready),
        .o_count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Monitor: samples mid-cycle, between driver updates and the edge.
    always @(negedge clk) begin
        logic [W-1:0] exp_w;
        logic         tin;
        logic         tout;
        tin  = din_valid && din_ready;
        tout = dout_valid && dout_ready;
        if (armed) begin
            chk("count", 32'(count), 32'(mdl_cnt));
            if (prev_stall) begin
                chk("hold_valid", 32'(dout_valid), 32'd1);
                chk("hold_data", 32'(dout), 32'(prev_dout));
            end
            if (tout) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 32'(dout), 32'hFFFF_FFFF);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk("dout_order", 32'(dout), 32'(exp_w));
                end
            end
        end
        if (rst || flush) begin
            sb_q.delete();
            mdl_cnt = 0;
            prev_stall = 1'b0;
            if (rst) armed = 1'b1;
        end else begin
            if (tin) sb_q.push_back(din);
            mdl_cnt = mdl_cnt + int'(tin) - int'(tout);
            prev_stall = dout_valid && !dout_ready;
            prev_dout = dout;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        din = 8'hAA; din_valid = 1'b1; dout_ready = 1'b1;
        tick();
        tick();
        settle();
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        tick();
        rst = 1'b0; din_valid = 1'b0;
        settle();
        chk("rst_din_ready", 32'(din_ready), 32'd1);
        tick();

        // Streaming 0x01..0x10 back-to-back.
        for (int c = 0; c < 19; c++) begin
            din_valid = (c < 16);
            din = 8'(c + 1);
            dout_ready = 1'b1;
            settle();
            if (c < 3) begin
                chk("stream_lat_empty", 32'(dout_valid), 32'd0);
            end else begin
                chk("stream_valid", 32'(dout_valid), 32'd1);
                chk("stream_data", 32'(dout), 32'(c - 2));
            end
            if (c >= 3 && c <= 16) chk("stream_count", 32'(count), 32'd3);
            if (c < 16) chk("stream_din_ready", 32'(din_ready), 32'd1);
            tick();
        end
        din_valid = 1'b0;
        settle();
        chk("stream_drained", 32'(count), 32'd0);
        tick();

        // Backpressure and fill.
        dout_ready = 1'b0;
        din_valid = 1'b1;
        din = 8'h11; tick();
        din = 8'h22; tick();
        din = 8'h33; tick();
        din = 8'h44;
        settle();
        chk("bp_full_ready", 32'(din_ready), 32'd0);
        chk("bp_count", 32'(count), 32'd3);
        chk("bp_dout", 32'(dout), 32'h11);
        tick();
        dout_ready = 1'b1;
        settle();
        chk("bp_passthru", 32'(din_ready), 32'd1);
        tick();
        din_valid = 1'b0;
        settle();
        chk("bp_dout2", 32'(dout), 32'h22);
        chk("bp_count2", 32'(count), 32'd3);
        tick();
        settle();
        chk("bp_dout3", 32'(dout), 32'h33);
        tick();
        settle();
        chk("bp_dout4", 32'(dout), 32'h44);
        chk("bp_count4", 32'(count), 32'd1);
        tick();

        // Bubble collapse.
        dout_ready = 1'b0;
        din_valid = 1'b1; din = 8'h55; tick();
        din_valid = 1'b0; tick();
        din_valid = 1'b1; din = 8'h66; tick();
        din_valid = 1'b0;
        settle();
        chk("bub_count", 32'(count), 32'd2);
        chk("bub_dout", 32'(dout), 32'h55);
        tick();
        settle();
        chk("bub_count2", 32'(count), 32'd2);
        chk("bub_dout2", 32'(dout), 32'h55);
        chk("bub_din_ready", 32'(din_ready), 32'd1);
        tick();
        dout_ready = 1'b1;
        tick(); tick(); tick();
        settle();
        chk("bub_drained", 32'(count), 32'd0);
        tick();

        // Flush of a full, stalled pipe.
        dout_ready = 1'b0;
        din_valid = 1'b1;
        din = 8'h70; tick();
        din = 8'h71; tick();
        din = 8'h72; tick();
        flush = 1'b1; din = 8'h99;
        settle();
        chk("fl_din_ready", 32'(din_ready), 32'd0);
        chk("fl_dout_valid", 32'(dout_valid), 32'd1);
        tick();
        flush = 1'b0; din_valid = 1'b0;
        settle();
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_dout_valid0", 32'(dout_valid), 32'd0);
        dout_ready = 1'b1;
        tick(); tick(); tick();
        settle();
        chk("fl_no99", 32'(dout_valid), 32'd0);
        tick();

        // Random soak with occasional flush/reset.
        for (int c = 0; c < 40000; c++) begin
            din        = W'($urandom);
            din_valid  = $urandom_range(0, 1) == 1;
            dout_ready = $urandom_range(0, 1) == 1;
            flush      = $urandom_range(0, 99) == 0;
            rst        = $urandom_range(0, 99) == 0;
            tick();
        end
        rst = 1'b0; flush = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
        for (int c = 0; c < S + 2; c++) tick();
        settle();
        chk("soak_drain_q", 32'(sb_q.size()), 32'd0);
        chk("soak_drain_cnt", 32'(count), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
